// File: rtl/retire_multi_pkg.sv
// Shared types and default sizes for the retire unit and its reorder buffer.
package retire_multi_pkg;
    localparam int ROB_DEPTH_DEF         = 16;
    localparam int RETIRE_WIDTH_DEF      = 2;
    localparam int WB_PORTS_DEF          = 2;
    localparam int PHY_RF_ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF        = 32;
    localparam int ROB_AW_DEF            = $clog2(ROB_DEPTH_DEF);

    typedef logic [ROB_AW_DEF-1:0] rob_addr_t;

    typedef enum logic [1:0] {
        ROB_STATE_FREE    = 2'd0,
        ROB_STATE_PENDING = 2'd1,
        ROB_STATE_DONE    = 2'd2
    } rob_state_t;

    typedef struct packed {
        rob_state_t                       state;
        logic [PHY_RF_ADDR_WIDTH_DEF-1:0] dest;
        logic [DATA_WIDTH_DEF-1:0]        value;
    } rob_entry_t;
endpackage

// File: rtl/retire_multi_if.sv
// Rename/writeback/retire bundle of the retire unit; master drives alloc/wb/flush.
interface retire_multi_if
    import retire_multi_pkg::*;
#(
    parameter int ROB_DEPTH         = ROB_DEPTH_DEF,
    parameter int RETIRE_WIDTH      = RETIRE_WIDTH_DEF,
    parameter int WB_PORTS          = WB_PORTS_DEF,
    parameter int PHY_RF_ADDR_WIDTH = PHY_RF_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF
);
    localparam int AW = $clog2(ROB_DEPTH);

    logic                                  alloc_en;
    logic [PHY_RF_ADDR_WIDTH-1:0]          alloc_dest;
    logic [AW-1:0]                         rob_tail_ptr;
    logic                                  rob_full;
    logic                                  rob_empty;
    logic [WB_PORTS-1:0]                   wb_en;
    logic [WB_PORTS*AW-1:0]                wb_rob_addr;
    logic [WB_PORTS*DATA_WIDTH-1:0]        wb_value;
    logic [RETIRE_WIDTH-1:0]               ret_en;
    logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0] ret_dest;
    logic [RETIRE_WIDTH*DATA_WIDTH-1:0]    ret_value;
    logic [RETIRE_WIDTH*AW-1:0]            ret_rob_addr;
    logic                                  flush;

    modport master (
        output alloc_en, alloc_dest, wb_en, wb_rob_addr, wb_value, flush,
        input  rob_tail_ptr, rob_full, rob_empty, ret_en, ret_dest, ret_value, ret_rob_addr
    );
    modport slave (
        input  alloc_en, alloc_dest, wb_en, wb_rob_addr, wb_value, flush,
        output rob_tail_ptr, rob_full, rob_empty, ret_en, ret_dest, ret_value, ret_rob_addr
    );
endinterface

// File: rtl/retire_multi_retire_select.sv
// Prefix-DONE detector: lane i retires only if lanes 0..i are DONE and occupied.
module retire_multi_retire_select #(
    parameter int RETIRE_WIDTH = 2,
    parameter int CNT_W        = 5,
    parameter int NW           = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic [RETIRE_WIDTH-1:0] done,
    input  logic [CNT_W-1:0]        count,
    output logic [RETIRE_WIDTH-1:0] ret_en,
    output logic [NW-1:0]           nret
);
    logic run;

    always_comb begin
        ret_en = '0;
        nret   = '0;
        run    = 1'b1;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            run       = run && done[i] && (CNT_W'(i) < count);
            ret_en[i] = run;
            if (run) nret = nret + 1'b1;
        end
    end
endmodule

// File: rtl/retire_multi.sv
// In-order multi-lane retire unit with integrated ROB.
// Optional QU_RETIRE_STATS_EN adds a saturating 32-bit retired-entry counter.
module retire_multi
    import retire_multi_pkg::*;
#(
    parameter int ROB_DEPTH         = ROB_DEPTH_DEF,
    parameter int RETIRE_WIDTH      = RETIRE_WIDTH_DEF,
    parameter int WB_PORTS          = WB_PORTS_DEF,
    parameter int PHY_RF_ADDR_WIDTH = PHY_RF_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef QU_RETIRE_STATS_EN
    output logic [31:0] ret_count,
`endif
    retire_multi_if.slave bus
);
    localparam int AW = $clog2(ROB_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(RETIRE_WIDTH + 1);
    localparam int PW = PHY_RF_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    rob_state_t    state     [ROB_DEPTH];
    logic [PW-1:0] dest_mem  [ROB_DEPTH];
    logic [DW-1:0] value_mem [ROB_DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    logic [AW-1:0]           lane_idx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] done;
    logic [RETIRE_WIDTH-1:0] ret_en;
    logic [NW-1:0]           nret;
    logic                    full, alloc_ok;

    // Fullness comes from the registered count, so a same-cycle retire never frees a slot early.
    assign full     = (count == CW'(ROB_DEPTH));
    assign alloc_ok = bus.alloc_en && !full;

    assign bus.rob_full     = full;
    assign bus.rob_empty    = (count == '0);
    assign bus.rob_tail_ptr = tail;
    assign bus.ret_en       = ret_en;

    always_comb begin
        done             = '0;
        bus.ret_dest     = '0;
        bus.ret_value    = '0;
        bus.ret_rob_addr = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            lane_idx[i]                  = head + AW'(i);
            done[i]                      = (state[lane_idx[i]] == ROB_STATE_DONE);
            bus.ret_dest[i*PW +: PW]     = dest_mem[lane_idx[i]];
            bus.ret_value[i*DW +: DW]    = value_mem[lane_idx[i]];
            bus.ret_rob_addr[i*AW +: AW] = lane_idx[i];
        end
    end

    retire_multi_retire_select #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .CNT_W        (CW),
        .NW           (NW)
    ) u_select (
        .done   (done),
        .count  (count),
        .ret_en (ret_en),
        .nret   (nret)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) state[e] <= ROB_STATE_FREE;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) state[e] <= ROB_STATE_FREE;
        end else begin
            for (int i = 0; i < RETIRE_WIDTH; i++)
                if (ret_en[i]) state[lane_idx[i]] <= ROB_STATE_FREE;
            for (int p = 0; p < WB_PORTS; p++)
                if (bus.wb_en[p] && state[bus.wb_rob_addr[p*AW +: AW]] == ROB_STATE_PENDING)
                    state[bus.wb_rob_addr[p*AW +: AW]] <= ROB_STATE_DONE;
            if (alloc_ok) state[tail] <= ROB_STATE_PENDING;
            head  <= head + AW'(nret);
            tail  <= tail + AW'(alloc_ok);
            count <= count + CW'(alloc_ok) - CW'(nret);
        end
    end

    // Payload storage is unreset; the state array alone decides validity. Later ports win.
    always_ff @(posedge clk) begin
        if (alloc_ok) dest_mem[tail] <= bus.alloc_dest;
        for (int p = 0; p < WB_PORTS; p++)
            if (bus.wb_en[p] && state[bus.wb_rob_addr[p*AW +: AW]] == ROB_STATE_PENDING)
                value_mem[bus.wb_rob_addr[p*AW +: AW]] <= bus.wb_value[p*DW +: DW];
    end

`ifdef QU_RETIRE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ret_count <= '0;
        else if (ret_count > 32'hFFFF_FFFF - 32'(nret))
            ret_count <= '1;
        else
            ret_count <= ret_count + 32'(nret);
    end
`endif
endmodule

// File: doc/retire_multi.md
Name: retire_multi

Overview:
- Parametrised in-order retire unit with integrated reorder buffer (ROB).
- Allocates ROB entries at the rename stage and accepts out-of-order results from multiple writeback ports.
- Retires up to RETIRE_WIDTH completed entries per cycle, in program order.
- Drives the physical register file, the busy-table clear and the reservation-station retire broadcast. Supports a full pipeline flush.

Parameters:
ROB_DEPTH, 16, ROB entries; power of two, >= 4
RETIRE_WIDTH, 2, max entries retired per cycle; 1..4
WB_PORTS, 2, writeback ports
PHY_RF_ADDR_WIDTH, 6, physical register address width
DATA_WIDTH, 32, result value width

Ports:
clk  in  1  clock
rst  in  1  reset
alloc_en  in  1  rename requests one entry at tail
alloc_dest  in  PHY_RF_ADDR_WIDTH  destination physical register of allocated entry
rob_tail_ptr  out  AW=$clog2(ROB_DEPTH)  index granted to the current alloc
rob_full  out  1  no free entry
rob_empty  out  1  no occupied entry
wb_en  in  WB_PORTS  per-port result valid
wb_rob_addr  in  WB_PORTS*AW  target entry per port
wb_value  in  WB_PORTS*DATA_WIDTH  result per port
ret_en  out  RETIRE_WIDTH  lane i retires this cycle
ret_dest  out  RETIRE_WIDTH*PHY_RF_ADDR_WIDTH  per-lane RF write / busy-clear address
ret_value  out  RETIRE_WIDTH*DATA_WIDTH  per-lane RF write data
ret_rob_addr  out  RETIRE_WIDTH*AW  per-lane ROB index (reservation-station broadcast)
flush  in  1  discard all entries

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: head=tail=0, count=0, all entries FREE. Outputs: ret_en=0, rob_full=0, rob_empty=1, rob_tail_ptr=0.
- Entry states:
  - FREE -> PENDING on alloc.
  - PENDING -> DONE on writeback.
  - DONE -> FREE on retire.
- Allocation: if alloc_en && !rob_full, then at the edge: entry[tail] := {PENDING, alloc_dest}, tail := tail+1 mod ROB_DEPTH. When full, alloc is ignored with no state change.
- rob_full is based on the registered count only, so an alloc in the same cycle as a retire from a full ROB is still refused.
- Writeback: wb_en[p] targeting a PENDING entry stores the value and sets DONE at the edge. Writeback to a FREE or DONE entry is ignored. If two ports hit the same entry in the same cycle, the higher port index wins.
- Retire selection (combinational from registered state): lane i asserts iff entries head..head+i are all DONE and i < count. Lanes are a contiguous prefix; lane 0 is always the oldest. ret_* lanes are valid only when ret_en=1; otherwise ret_dest and ret_value are don't-care.
- At the edge: retired entries go FREE, head += nret, count := count + alloc_ok - nret. Counter width is AW+1, so head/tail wrap modulo ROB_DEPTH.
- Latency: writeback at cycle t -> earliest retire at cycle t+1. Alloc at t -> earliest writeback at t+1.
- Flush: highest priority. At the edge, all entries go FREE and head=tail=count=0; same-cycle alloc/wb are discarded. ret_en is still asserted in the flush cycle (those retires commit).
- Reset asserted mid-operation: all state is cleared immediately, regardless of the clock.

Optional Feature:
- Macro QU_RETIRE_STATS_EN.
- Defined: adds output ret_count (32 bits, reset 0), incremented by nret each cycle; it saturates at 2^32-1 and flush does not clear it.
- Undefined: the port and counter are absent.

Decomposition:
- qu_common: ROB_DEPTH, RETIRE_WIDTH defaults; rob_addr_t; rob_state_t enum {ROB_STATE_FREE, ROB_STATE_PENDING, ROB_STATE_DONE}; rob_entry_t {state, dest, value}.
- Sub-module retire_select: combinational prefix-DONE detector producing ret_en and nret from the head-rotated state vector and count.

Test Plan:
- Reset, then 3 allocs (dest 5,6,7); wb entry 1 then entry 0 (0xA, 0xB) -> cycle after the second wb: ret_en=2'b11, ret_dest={6,5}, ret_value={0xA,0xB}; the next cycle, entry 2 still pending, ret_en=0.
- Fill 16 entries -> rob_full=1; alloc while full is ignored and tail stays 0. Retire 1 and alloc in the same cycle -> alloc refused. Next cycle alloc accepted at index 0; count=16.
- Wrap: head=14, entries 14,15,0 all DONE -> lanes retire 14,15 this cycle, then 0 the next; head=1.
- Both wb ports hit entry 3 with 0x11/0x22 -> retired value 0x22. wb to a FREE entry -> no retire, count unchanged.
- 5 PENDING entries, flush together with alloc and wb -> next cycle rob_empty=1, tail=0, ret_en=0.
- Async reset pulse between edges with 4 DONE entries -> outputs return to reset values immediately. With QU_RETIRE_STATS_EN, ret_count=0.
